// File: rtl/serial_fifo_param_if.sv
// Handshake/bus bundle for serial_fifo_param: serial input, dequeue request,
// popped word and status/pulse flags.
interface serial_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
);
   logic                       data_in;
   logic                       write_in;
   logic                       dequeue_in;
   logic [DATA_W-1:0]          data_out;
   logic                       valid_out;
   logic                       full_out;
   logic                       empty_out;
   logic [$clog2(DEPTH+1)-1:0] count_out;
   logic                       overflow_out;
   logic                       underflow_out;
   logic                       frame_err_out;

   modport master (
      output data_in, write_in, dequeue_in,
      input  data_out, valid_out, full_out, empty_out, count_out,
             overflow_out, underflow_out, frame_err_out
   );

   modport slave (
      input  data_in, write_in, dequeue_in,
      output data_out, valid_out, full_out, empty_out, count_out,
             overflow_out, underflow_out, frame_err_out
   );
endinterface

// File: rtl/serial_fifo_param.sv
// Gated serial-in deserialiser feeding a DEPTH-entry circular FIFO, popped on
// rising edges of dequeue_in, with occupancy count and event pulse flags.
module serial_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int BIT_DIV   = 10,
   parameter int MSB_FIRST = 1
) (
   input logic               clock1M,
   input logic               reset,
   serial_fifo_param_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = $clog2(BIT_DIV);
   localparam int BW = $clog2(DATA_W);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHIFT    = 2'd1;
   localparam logic [1:0] PUSH     = 2'd2;
   localparam logic [1:0] WAIT_LOW = 2'd3;

   localparam logic [DW-1:0] DIV_LAST   = DW'(BIT_DIV - 1);
   // div holds cycles since E0 mod BIT_DIV, so the sample edge sees the value one below
   localparam logic [DW-1:0] DIV_SAMPLE = DW'(BIT_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

   logic [1:0]        state;
   logic [DW-1:0]     div;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              dequeue_q;
   logic [DATA_W-1:0] data_r;
   logic              valid_r, ovf_r, unf_r, ferr_r;

   logic full, empty, pop_req, pop_ok, push, push_ok, sample;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign pop_req = bus.dequeue_in & ~dequeue_q;
   assign pop_ok  = pop_req & ~empty;
   assign push    = (state == PUSH);
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands
   assign push_ok = push & (~full | pop_ok);
   assign sample  = (state == SHIFT) & bus.write_in & (div == DIV_SAMPLE);

   always_ff @(posedge clock1M or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         div     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         ferr_r  <= 1'b0;
      end else begin
         ferr_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.write_in) begin
                  state   <= SHIFT;
                  div     <= '0;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (!bus.write_in) begin
                  ferr_r <= 1'b1;
                  state  <= IDLE;
               end else begin
                  div <= (div == DIV_LAST) ? '0 : div + DW'(1);
                  if (sample) begin
                     if (MSB_FIRST != 0) shreg <= {shreg[DATA_W-2:0], bus.data_in};
                     else                shreg <= {bus.data_in, shreg[DATA_W-1:1]};
                     bit_cnt <= bit_cnt + BW'(1);
                     if (bit_cnt == BIT_LAST) state <= PUSH;
                  end
               end
            end
            PUSH:    state <= WAIT_LOW;
            default: if (!bus.write_in) state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock1M or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dequeue_q <= 1'b0;
         data_r    <= '0;
         valid_r   <= 1'b0;
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
      end else begin
         dequeue_q <= bus.dequeue_in;
         valid_r   <= pop_ok;
         unf_r     <= pop_req & empty;
         ovf_r     <= push & ~push_ok;
         if (pop_ok) begin
            data_r <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (push_ok && !pop_ok)      count <= count + CW'(1);
         else if (!push_ok && pop_ok) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock1M) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   assign bus.data_out      = data_r;
   assign bus.valid_out     = valid_r;
   assign bus.full_out      = full;
   assign bus.empty_out     = empty;
   assign bus.count_out     = count;
   assign bus.overflow_out  = ovf_r;
   assign bus.underflow_out = unf_r;
   assign bus.frame_err_out = ferr_r;
endmodule

// File: tb/tb_serial_fifo_param.sv
// Scoreboard bench: default instance (a) and 12-bit/4-deep/LSB-first instance (b)
// against a queue-based FIFO model; a negedge monitor checks every popped word.
module tb_serial_fifo_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic sel  = 1'b0;
   logic d_in = 1'b0;
   logic wr   = 1'b0;
   logic deq  = 1'b0;

   serial_fifo_param_if #(.DATA_W(8),  .DEPTH(8)) ifa ();
   serial_fifo_param_if #(.DATA_W(12), .DEPTH(4)) ifb ();

   assign ifa.data_in    = d_in & ~sel;
   assign ifa.write_in   = wr   & ~sel;
   assign ifa.dequeue_in = deq  & ~sel;
   assign ifb.data_in    = d_in & sel;
   assign ifb.write_in   = wr   & sel;
   assign ifb.dequeue_in = deq  & sel;

   serial_fifo_param #(.DATA_W(8), .DEPTH(8), .BIT_DIV(10), .MSB_FIRST(1)) dut_a (
      .clock1M(clk), .reset(rst), .bus(ifa)
   );
   serial_fifo_param #(.DATA_W(12), .DEPTH(4), .BIT_DIV(6), .MSB_FIRST(0)) dut_b (
      .clock1M(clk), .reset(rst), .bus(ifb)
   );

   // reference model: FIFO contents, expected popped words, event counts
   logic [11:0] mq_a[$], mq_b[$], eq_a[$], eq_b[$];
   logic [11:0] last[2] = '{12'h0, 12'h0};
   int exp_ovf[2]  = '{0, 0};
   int exp_unf[2]  = '{0, 0};
   int exp_ferr[2] = '{0, 0};
   int exp_pops[2] = '{0, 0};
   int act_ovf[2]  = '{0, 0};
   int act_unf[2]  = '{0, 0};
   int act_ferr[2] = '{0, 0};
   int act_vld[2]  = '{0, 0};
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (ifa.overflow_out)  act_ovf[0]++;
      if (ifa.underflow_out) act_unf[0]++;
      if (ifa.frame_err_out) act_ferr[0]++;
      if (ifb.overflow_out)  act_ovf[1]++;
      if (ifb.underflow_out) act_unf[1]++;
      if (ifb.frame_err_out) act_ferr[1]++;
      if (ifa.valid_out) begin
         act_vld[0]++;
         if (eq_a.size() == 0) chk("data_a_unexpected_valid", 32'(ifa.data_out), 32'hFFFF_FFFF);
         else chk("data_a", 32'(ifa.data_out), 32'(eq_a.pop_front()));
      end
      if (ifb.valid_out) begin
         act_vld[1]++;
         if (eq_b.size() == 0) chk("data_b_unexpected_valid", 32'(ifb.data_out), 32'hFFFF_FFFF);
         else chk("data_b", 32'(ifb.data_out), 32'(eq_b.pop_front()));
      end
   end

   function automatic int dut_count(input bit s);
      return s ? int'(ifb.count_out) : int'(ifa.count_out);
   endfunction

   task automatic model_pop(input bit s);
      logic [11:0] v;
      if (!s) begin
         if (mq_a.size() == 0) exp_unf[0]++;
         else begin v = mq_a.pop_front(); eq_a.push_back(v); last[0] = v; exp_pops[0]++; end
      end else begin
         if (mq_b.size() == 0) exp_unf[1]++;
         else begin v = mq_b.pop_front(); eq_b.push_back(v); last[1] = v; exp_pops[1]++; end
      end
   endtask

   task automatic model_push(input bit s, input logic [11:0] w);
      if (!s) begin
         if (mq_a.size() < 8) mq_a.push_back(w); else exp_ovf[0]++;
      end else begin
         if (mq_b.size() < 4) mq_b.push_back(w); else exp_ovf[1]++;
      end
   endtask

   function automatic int model_size(input bit s);
      return s ? mq_b.size() : mq_a.size();
   endfunction

   task automatic check_state(input bit s, input string tag);
      int sz  = model_size(s);
      int dep = s ? 4 : 8;
      chk({tag, "/count"}, 32'(dut_count(s)), 32'(sz));
      chk({tag, "/full"},  32'(s ? ifb.full_out  : ifa.full_out),  32'(sz == dep));
      chk({tag, "/empty"}, 32'(s ? ifb.empty_out : ifa.empty_out), 32'(sz == 0));
      chk({tag, "/data_out"}, s ? 32'(ifb.data_out) : 32'(ifa.data_out), 32'(last[s]));
      chk({tag, "/overflows"},  32'(act_ovf[s]),  32'(exp_ovf[s]));
      chk({tag, "/underflows"}, 32'(act_unf[s]),  32'(exp_unf[s]));
      chk({tag, "/frame_errs"}, 32'(act_ferr[s]), 32'(exp_ferr[s]));
      chk({tag, "/valids"},     32'(act_vld[s]),  32'(exp_pops[s]));
   endtask

   // Serial frame: bit k is driven from just after edge E0+k*bd-1, so it is stable
   // around its sample edge E0+k*bd+bd/2. abort_after<width drops write_in there.
   task automatic send(input bit s, input logic [11:0] w, input int abort_after, input bit pop_at_push);
      int dw = s ? 12 : 8;
      int bd = s ? 6 : 10;
      bit aborted = 1'b0;
      logic [11:0] ww = w;
      @(posedge clk); #1;
      sel = s;
      wr  = 1'b1;
      for (int k = 0; k < dw; k++) begin
         if (k == abort_after) begin
            wr = 1'b0; d_in = 1'b0; aborted = 1'b1;
            break;
         end
         d_in = s ? ww[k] : ww[dw-1-k];
         if (k < dw - 1) begin
            repeat (bd) @(posedge clk);
            #1;
         end
      end
      if (aborted) begin
         exp_ferr[s]++;
      end else begin
         repeat (bd / 2 + 1) @(posedge clk);
         #1;
         chk(s ? "pre_push_count_b" : "pre_push_count_a", 32'(dut_count(s)), 32'(model_size(s)));
         if (pop_at_push) deq = 1'b1;
         @(posedge clk); #1;
         wr = 1'b0; d_in = 1'b0;
         if (pop_at_push) model_pop(s);
         model_push(s, w);
         chk(s ? "post_push_count_b" : "post_push_count_a", 32'(dut_count(s)), 32'(model_size(s)));
         if (pop_at_push) begin
            repeat (3) @(posedge clk);
            #1 deq = 1'b0;
         end
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic dequeue(input bit s, input int hold);
      @(posedge clk); #1;
      sel = s;
      deq = 1'b1;
      @(posedge clk); #1;
      model_pop(s);
      repeat (hold - 1) @(posedge clk);
      #1 deq = 1'b0;
      @(posedge clk); #1;
   endtask

   logic [7:0] pat8 [8] = '{8'hAA, 8'hCC, 8'hF0, 8'h0F, 8'h33, 8'h55, 8'h99, 8'hFF};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check_state(0, "reset_a");
      check_state(1, "reset_b");

      for (int i = 0; i < 4; i++) send(0, 12'(pat8[i]), 99, 0);
      check_state(0, "four_words");
      for (int i = 0; i < 4; i++) dequeue(0, 100);
      check_state(0, "four_drained");

      for (int i = 0; i < 8; i++) send(0, 12'(pat8[i]), 99, 0);
      check_state(0, "filled");
      send(0, 12'h000, 99, 0);
      check_state(0, "overflow");
      for (int i = 0; i < 8; i++) dequeue(0, 3);
      check_state(0, "drained");
      dequeue(0, 2);
      check_state(0, "underflow");

      send(0, 12'h077, 3, 0);
      check_state(0, "abort");
      send(0, 12'h05A, 99, 0);
      dequeue(0, 2);
      check_state(0, "after_abort");

      for (int i = 0; i < 8; i++) send(0, 12'($urandom & 8'hFF), 99, 0);
      send(0, 12'h0C3, 99, 1);
      check_state(0, "full_push_pop");
      for (int i = 0; i < 8; i++) dequeue(0, 1 + (i % 3));
      check_state(0, "full_push_pop_drained");

      send(0, 12'h012, 99, 0);
      send(0, 12'h034, 99, 0);
      dequeue(0, 2);
      check_state(0, "pre_reset");
      @(posedge clk); #1;
      sel = 1'b0; wr = 1'b1; d_in = 1'b1;
      repeat (40) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst/data_out",  32'(ifa.data_out),      32'h0);
      chk("rst/valid",     32'(ifa.valid_out),     32'h0);
      chk("rst/count",     32'(ifa.count_out),     32'h0);
      chk("rst/empty",     32'(ifa.empty_out),     32'h1);
      chk("rst/full",      32'(ifa.full_out),      32'h0);
      chk("rst/overflow",  32'(ifa.overflow_out),  32'h0);
      chk("rst/underflow", 32'(ifa.underflow_out), 32'h0);
      chk("rst/frame_err", 32'(ifa.frame_err_out), 32'h0);
      wr = 1'b0; d_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mq_a.delete(); mq_b.delete();
      last[0] = 12'h0; last[1] = 12'h0;
      repeat (20) @(posedge clk);
      #1;
      check_state(0, "after_reset");

      send(1, 12'hABC, 99, 0);
      dequeue(1, 2);
      check_state(1, "variant_abc");
      for (int i = 0; i < 4; i++) send(1, 12'($urandom & 12'hFFF), 99, 0);
      check_state(1, "variant_full");
      send(1, 12'h123, 99, 0);
      check_state(1, "variant_overflow");
      send(1, 12'h456, 99, 1);
      check_state(1, "variant_push_pop");
      for (int i = 0; i < 5; i++) dequeue(1, 2);
      check_state(1, "variant_drained");

      for (int i = 0; i < 60; i++) begin
         bit s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0)
            send(s, 12'($urandom) & (s ? 12'hFFF : 12'h0FF), 99, 1'($urandom_range(0, 3) == 0));
         else
            dequeue(s, $urandom_range(1, 4));
         if (i % 10 == 9) begin
            check_state(0, "random_a");
            check_state(1, "random_b");
         end
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_a", 32'(eq_a.size()), 32'h0);
      chk("pending_b", 32'(eq_b.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
